// File: rtl/clk_sync_multi_if.sv
// -----------------------------------------------------------------------------
// clk_sync_multi_if
// Bundles the per-core lockstep signals of the clock gater.
//   retire_i      per-core retire strobe (rvfi_valid), driven by the core side
//   done_i        per-core "finished" flag, driven by the core side
//   clk_o         gated per-core clocks
//   retire_o      one-cycle pulse when every active core has retired
//   held_o        cores frozen after retiring
//   retire_cnt_o  saturating count of retire_o pulses
//   desync_o      sticky desync (timeout) flag
//   finished_o    sticky all-cores-done flag
// Modports:
//   master  the core/verification side (drives retire_i, done_i)
//   slave   the gater itself (drives everything else)
// NUM_CORES and CNT_W must match the parameters of the attached gater.
// -----------------------------------------------------------------------------
interface clk_sync_multi_if #(
   parameter int NUM_CORES = 2,
   parameter int CNT_W     = 16
);
   logic [NUM_CORES-1:0] retire_i;
   logic [NUM_CORES-1:0] done_i;
   logic [NUM_CORES-1:0] clk_o;
   logic                 retire_o;
   logic [NUM_CORES-1:0] held_o;
   logic [CNT_W-1:0]     retire_cnt_o;
   logic                 desync_o;
   logic                 finished_o;

   modport master (
      output retire_i,
      output done_i,
      input  clk_o,
      input  retire_o,
      input  held_o,
      input  retire_cnt_o,
      input  desync_o,
      input  finished_o
   );

   modport slave (
      input  retire_i,
      input  done_i,
      output clk_o,
      output retire_o,
      output held_o,
      output retire_cnt_o,
      output desync_o,
      output finished_o
   );
endinterface

// File: rtl/clk_sync_multi.sv
// -----------------------------------------------------------------------------
// clk_sync_multi
// Lockstep clock gater for NUM_CORES core copies. Each copy gets a gated clock
// and runs until it retires one instruction, then it is frozen. When every
// active (not done) copy has retired, a single retire pulse is issued and all
// copies are released together. A core that raises done_i is excluded from the
// lockstep condition. If the copies fail to line up within TIMEOUT cycles the
// gater stops every clock and flags desync; once all cores are done it stops
// every clock and flags finished.
//
// Ports:
//   clk_i   master clock
//   rst_i   synchronous, active-high reset
//   bus     clk_sync_multi_if.slave (retire_i/done_i in, gated clocks and
//           status out)
// -----------------------------------------------------------------------------
module clk_sync_multi #(
   parameter int NUM_CORES = 2,
   parameter int TIMEOUT   = 64,
   parameter int CNT_W     = 16
) (
   input logic             clk_i,
   input logic             rst_i,
   clk_sync_multi_if.slave bus
);

   // Timer only has to count up to TIMEOUT-1; keep at least one bit.
   localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_WAIT    = 3'd1,
      ST_RELEASE = 3'd2,
      ST_ERR     = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Saturating increment for the retire counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + CNT_W'(1'b1);
      end
      return r;
   endfunction

   state_t               state_r;
   state_t               state_s;
   logic [NUM_CORES-1:0] held_r;
   logic [NUM_CORES-1:0] held_s;
   logic [NUM_CORES-1:0] en_n_r;
   logic [NUM_CORES-1:0] run_s;
   logic [NUM_CORES-1:0] capture_s;
   logic [TIMER_W-1:0]   timer_r;
   logic [TIMER_W-1:0]   timer_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [CNT_W-1:0]     cnt_s;
   logic                 retire_r;
   logic                 desync_r;
   logic                 finished_r;
   logic                 all_done_s;
   logic                 all_ok_s;

   // A retire only counts on an edge the core actually saw (clock enabled) and
   // only for a core that is neither frozen nor done.
   always_comb begin
      capture_s  = en_n_r & bus.retire_i & ~held_r & ~bus.done_i;
      all_done_s = &bus.done_i;
      // done_i is combinational here so a core finishing while others wait
      // satisfies the lockstep condition in that same cycle.
      all_ok_s   = (&(held_r | bus.done_i)) & (|held_r);
   end

   // Per-core clock enable request: only in RUN/WAIT, and only for cores that
   // are still live and not frozen.
   always_comb begin
      run_s = {NUM_CORES{1'b0}};
      if ((state_r == ST_RUN) || (state_r == ST_WAIT)) begin
         run_s = ~held_r & ~bus.done_i;
      end else begin
         run_s = {NUM_CORES{1'b0}};
      end
   end

   // Next-state logic for the lockstep controller.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_RUN: begin
            // Entering WAIT on the capture edge itself keeps RUN free of held
            // cores and gives a one-cycle retire latency even when all cores
            // retire together.
            if (all_done_s) begin
               state_s = ST_DONE;
            end else if (|capture_s) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_WAIT: begin
            // all_ok wins over a coincident timeout.
            if (all_ok_s) begin
               state_s = ST_RELEASE;
            end else if (timer_r == TIMER_LAST) begin
               state_s = ST_ERR;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_RELEASE: begin
            if (all_done_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_ERR:  state_s = ST_ERR;
         ST_DONE: state_s = ST_DONE;
         // An illegal encoding is treated as a desync: stop all cores.
         default: state_s = ST_ERR;
      endcase
   end

   // Next values of held mask, WAIT timer and retire counter.
   always_comb begin
      held_s  = held_r;
      timer_s = timer_r;
      cnt_s   = cnt_r;

      if (state_r == ST_RELEASE) begin
         held_s = {NUM_CORES{1'b0}};
      end else begin
         held_s = held_r | capture_s;
      end

      // Timer is zero outside WAIT, so every WAIT entry starts from zero; it
      // parks at TIMER_LAST rather than wrapping.
      if (state_r == ST_WAIT) begin
         if (timer_r != TIMER_LAST) begin
            timer_s = timer_r + TIMER_W'(1'b1);
         end else begin
            timer_s = timer_r;
         end
      end else begin
         timer_s = {TIMER_W{1'b0}};
      end

      // Counter steps together with the retire pulse.
      if (state_s == ST_RELEASE) begin
         cnt_s = sat_inc(cnt_r);
      end else begin
         cnt_s = cnt_r;
      end
   end

   // Controller state, held mask, timer, counter and registered status outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= ST_RUN;
         held_r     <= {NUM_CORES{1'b0}};
         timer_r    <= {TIMER_W{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         retire_r   <= 1'b0;
         desync_r   <= 1'b0;
         finished_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         held_r     <= held_s;
         timer_r    <= timer_s;
         cnt_r      <= cnt_s;
         retire_r   <= (state_s == ST_RELEASE);
         desync_r   <= (state_s == ST_ERR);
         finished_r <= (state_s == ST_DONE);
      end
   end

   // Clock enables change only while clk_i is low so the AND gate below never
   // produces a runt pulse; clocks are held off during reset.
   always_ff @(negedge clk_i) begin
      if (rst_i) begin
         en_n_r <= {NUM_CORES{1'b0}};
      end else begin
         en_n_r <= run_s;
      end
   end

   assign bus.clk_o        = {NUM_CORES{clk_i}} & en_n_r;
   assign bus.retire_o     = retire_r;
   assign bus.held_o       = held_r;
   assign bus.retire_cnt_o = cnt_r;
   assign bus.desync_o     = desync_r;
   assign bus.finished_o   = finished_r;

endmodule

// File: tb/tb_clk_sync_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_sync_multi
// Directed bench for clk_sync_multi. Three instances share clk/rst:
//   dut_a  NUM_CORES=2, TIMEOUT=8,  CNT_W=16
//   dut_b  NUM_CORES=3, TIMEOUT=64, CNT_W=16
//   dut_c  NUM_CORES=2, TIMEOUT=64, CNT_W=2
// Inputs change 1 time unit after the rising clk edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_clk_sync_multi;

   logic clk;
   logic rst;

   int checks   = 0;
   int failures = 0;

   clk_sync_multi_if #(.NUM_CORES(2), .CNT_W(16)) if_a ();
   clk_sync_multi_if #(.NUM_CORES(3), .CNT_W(16)) if_b ();
   clk_sync_multi_if #(.NUM_CORES(2), .CNT_W(2))  if_c ();

   clk_sync_multi #(.NUM_CORES(2), .TIMEOUT(8), .CNT_W(16)) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_a)
   );

   clk_sync_multi #(.NUM_CORES(3), .TIMEOUT(64), .CNT_W(16)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_b)
   );

   clk_sync_multi #(.NUM_CORES(2), .TIMEOUT(64), .CNT_W(2)) dut_c (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gated clock pulse counters.
   int pa0 = 0;
   int pa1 = 0;
   int pb0 = 0;
   always @(posedge if_a.clk_o[0]) pa0 <= pa0 + 1;
   always @(posedge if_a.clk_o[1]) pa1 <= pa1 + 1;
   always @(posedge if_b.clk_o[0]) pb0 <= pb0 + 1;

   // retire_o pulse counters (each pulse spans exactly one falling edge).
   int ra = 0;
   int rb = 0;
   always @(negedge clk) if (if_a.retire_o) ra <= ra + 1;
   always @(negedge clk) if (if_b.retire_o) rb <= rb + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int s0;
   int s1;
   int r0;

   initial begin
      rst = 1'b1;
      if_a.retire_i = 2'b00; if_a.done_i = 2'b00;
      if_b.retire_i = 3'b000; if_b.done_i = 3'b000;
      if_c.retire_i = 2'b00; if_c.done_i = 2'b00;
      repeat (3) tick();

      // ---------------- reset state ----------------
      chk("rst_held",     if_a.held_o, 0);
      chk("rst_retire",   if_a.retire_o, 0);
      chk("rst_cnt",      if_a.retire_cnt_o, 0);
      chk("rst_desync",   if_a.desync_o, 0);
      chk("rst_finished", if_a.finished_o, 0);
      chk("rst_clk_a",    if_a.clk_o, 0);
      chk("rst_clk_b",    if_b.clk_o, 0);
      rst = 1'b0;

      // ---------------- N=2 lockstep x5 ----------------
      s0 = pa0; r0 = ra;
      for (int i = 0; i < 5; i++) begin
         if_a.retire_i = 2'b11;
         tick();
         chk("ls_held", if_a.held_o, 2'b11);
         chk("ls_ret_lo", if_a.retire_o, 0);
         if_a.retire_i = 2'b00;
         tick();
         chk("ls_ret_hi", if_a.retire_o, 1);
         chk("ls_cnt", if_a.retire_cnt_o, i + 1);
         tick();
         chk("ls_held_clr", if_a.held_o, 0);
         chk("ls_ret_end", if_a.retire_o, 0);
      end
      chk("ls_pulses", ra - r0, 5);
      chk("ls_cnt_final", if_a.retire_cnt_o, 5);
      chk("ls_desync", if_a.desync_o, 0);
      chk("ls_clk0_pulses", pa0 - s0, 5);

      // ---------------- reset in WAIT ----------------
      if_a.retire_i = 2'b01;
      tick();
      chk("rw_held", if_a.held_o, 2'b01);
      chk("rw_cnt_pre", if_a.retire_cnt_o, 5);
      r0 = ra;
      if_a.retire_i = 2'b00;
      rst = 1'b1;
      tick();
      chk("rw_held_clr", if_a.held_o, 0);
      chk("rw_cnt_clr", if_a.retire_cnt_o, 0);
      chk("rw_no_retire", if_a.retire_o, 0);
      chk("rw_clk_off", if_a.clk_o, 0);
      rst = 1'b0;
      s0 = pa0;
      tick();
      chk("rw_clk_restart", pa0 - s0, 1);
      chk("rw_no_pulse", ra - r0, 0);

      // ---------------- desync timeout (TIMEOUT=8) ----------------
      if_a.retire_i = 2'b01;
      tick();
      chk("to_held", if_a.held_o, 2'b01);
      if_a.retire_i = 2'b00;
      repeat (7) tick();
      chk("to_desync_early", if_a.desync_o, 0);
      tick();
      chk("to_desync", if_a.desync_o, 1);
      chk("to_held_keep", if_a.held_o, 2'b01);
      s0 = pa0; s1 = pa1;
      tick();
      chk("to_clk_off", if_a.clk_o, 0);
      repeat (3) tick();
      chk("to_clk0_frozen", pa0 - s0, 0);
      chk("to_clk1_frozen", pa1 - s1, 0);
      chk("to_desync_sticky", if_a.desync_o, 1);

      // ---------------- done masking on core1 ----------------
      rst = 1'b1;
      if_a.done_i = 2'b10;
      tick();
      rst = 1'b0;
      s1 = pa1; r0 = ra;
      for (int i = 0; i < 3; i++) begin
         if_a.retire_i = 2'b11;   // core1 retire must be ignored
         tick();
         chk("dm_held", if_a.held_o, 2'b01);
         if_a.retire_i = 2'b00;
         tick();
         chk("dm_ret_hi", if_a.retire_o, 1);
         tick();
         chk("dm_held_clr", if_a.held_o, 0);
      end
      chk("dm_pulses", ra - r0, 3);
      chk("dm_cnt", if_a.retire_cnt_o, 3);
      chk("dm_clk1_none", pa1 - s1, 0);
      if_a.done_i = 2'b11;
      tick();
      chk("dm_finished", if_a.finished_o, 1);
      s0 = pa0;
      if_a.done_i = 2'b00;     // falling done must be ignored
      repeat (3) tick();
      chk("dm_finished_sticky", if_a.finished_o, 1);
      chk("dm_clk_off", if_a.clk_o, 0);
      chk("dm_clk0_frozen", pa0 - s0, 0);
      chk("dm_desync", if_a.desync_o, 0);

      // ---------------- N=3 staggered retires ----------------
      r0 = rb;
      if_b.retire_i = 3'b001;
      tick();                          // t: core0 captured
      chk("st_held_001", if_b.held_o, 3'b001);
      if_b.retire_i = 3'b000;
      s0 = pb0;
      repeat (2) tick();
      chk("st_held_001b", if_b.held_o, 3'b001);
      if_b.retire_i = 3'b100;
      tick();                          // t+3: core2 captured
      chk("st_held_101", if_b.held_o, 3'b101);
      if_b.retire_i = 3'b000;
      repeat (3) tick();
      chk("st_held_101b", if_b.held_o, 3'b101);
      chk("st_ret_lo", if_b.retire_o, 0);
      if_b.retire_i = 3'b010;
      tick();                          // t+7: core1 captured
      chk("st_held_111", if_b.held_o, 3'b111);
      chk("st_ret_lo2", if_b.retire_o, 0);
      if_b.retire_i = 3'b000;
      tick();
      chk("st_ret_hi", if_b.retire_o, 1);
      chk("st_cnt", if_b.retire_cnt_o, 1);
      chk("st_clk0_frozen", pb0 - s0, 0);
      tick();
      chk("st_held_clr", if_b.held_o, 0);
      chk("st_ret_end", if_b.retire_o, 0);
      s0 = pb0;
      tick();
      chk("st_clk0_resume", pb0 - s0, 1);
      chk("st_one_pulse", rb - r0, 1);

      // done_i rising on the non-held cores while waiting satisfies the wait
      if_b.retire_i = 3'b001;
      tick();
      chk("dw_held", if_b.held_o, 3'b001);
      if_b.retire_i = 3'b000;
      if_b.done_i = 3'b110;
      tick();
      chk("dw_ret_hi", if_b.retire_o, 1);
      chk("dw_cnt", if_b.retire_cnt_o, 2);

      // ---------------- CNT_W=2 saturation ----------------
      for (int i = 0; i < 5; i++) begin
         if_c.retire_i = 2'b11;
         tick();
         if_c.retire_i = 2'b00;
         tick();
         chk("sat_ret_hi", if_c.retire_o, 1);
         chk("sat_cnt", if_c.retire_cnt_o, (i < 3) ? i + 1 : 3);
         tick();
         chk("sat_held_clr", if_c.held_o, 0);
      end
      chk("sat_desync", if_c.desync_o, 0);
      chk("sat_finished", if_c.finished_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
